regfile_port_arbiter: RTL and testbench

- Shares the register file's two read ports and single write port between the core datapath (decode reads, writeback write) and a debug access port.
- Sits between instruction decode / writeback and the register file.
- The core has priority. A starvation counter forces a debug grant after a bounded wait; the core is stalled while debug owns the ports.
- Provides debug register read and write with a valid/ack handshake.

---
 rtl/regfile_port_arbiter.sv | 143 ++++++++++++++
 tb/tb_regfile_port_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_port_arbiter.sv
// regfile_port_arbiter
//
// Shares the register file's two read ports and one write port between the
// core datapath and a debug access port. The core normally owns the ports.
// A pending debug request takes the ports for exactly one cycle in either
// of two cases: the core is idle, or the debug request has waited
// STARVE_LIMIT contended cycles. While debug owns the ports, the core is
// stalled. The core must re-present its request, which is then served
// unchanged in the following CORE cycle.
//
// Handshake summary:
//   - dbg_req is a level held by the requester until dbg_ack is seen.
//   - dbg_ack pulses in the single cycle the access is performed.
//   - For reads, dbg_rvalid pulses one cycle after dbg_ack, with the
//     registered dbg_rdata.
//   - core_stall tells the core to hold its request and not advance.
//
// arb_state exposes the FSM state: 0 = CORE, 1 = DBG.
module regfile_port_arbiter #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 5,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  // core datapath side
  input  logic              core_valid,
  input  logic [ADDR_W-1:0] core_rs,
  input  logic [ADDR_W-1:0] core_rt,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_wa,
  input  logic [DATA_W-1:0] core_wd,
  output logic              core_stall,
  // debug access port
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_rvalid,
  // register file side
  output logic [ADDR_W-1:0] rf_raddr1,
  output logic [ADDR_W-1:0] rf_raddr2,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic [DATA_W-1:0] rf_rdata1,
  // FSM state observation
  output logic              arb_state
);

  typedef enum logic {
    ST_CORE = 1'b0,
    ST_DBG  = 1'b1
  } state_t;

  // An 8-bit counter covers the whole legal STARVE_LIMIT range (1..255).
  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  state_t     state;
  logic [7:0] starve_cnt;
  logic       starved;
  logic       grant;

  // Debug wins when the core leaves the ports free, or after the core has
  // held them for the full starvation window.
  assign starved = (starve_cnt == LIMIT);
  assign grant   = dbg_req & (~core_valid | starved);

  assign arb_state = logic'(state);

  // FSM, starvation counter and registered debug read return.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_CORE;
      starve_cnt <= 8'd0;
      dbg_rdata  <= '0;
      dbg_rvalid <= 1'b0;
    end else begin
      dbg_rvalid <= 1'b0;
      case (state)
        ST_CORE: begin
          if (grant) begin
            state      <= ST_DBG;
            starve_cnt <= 8'd0;
          end else if (!dbg_req) begin
            starve_cnt <= 8'd0;
          end else if (!starved) begin
            // dbg_req with a busy core: count toward the forced grant.
            starve_cnt <= starve_cnt + 8'd1;
          end
        end
        ST_DBG: begin
          // A debug grant lasts one cycle. At least one CORE cycle always
          // follows, so the core cannot be starved by debug in turn.
          state      <= ST_CORE;
          starve_cnt <= 8'd0;
          if (!dbg_we) begin
            dbg_rdata  <= rf_rdata1;
            dbg_rvalid <= 1'b1;
          end
        end
        default: begin
          state      <= ST_CORE;
          starve_cnt <= 8'd0;
        end
      endcase
    end
  end

  // Register file port steering. Writes to register 0 are suppressed for
  // both requesters.
  always_comb begin
    rf_raddr1  = core_rs;
    rf_raddr2  = core_rt;
    rf_waddr   = core_wa;
    rf_wdata   = core_wd;
    rf_we      = core_valid & core_we & (core_wa != '0);
    core_stall = 1'b0;
    dbg_ack    = 1'b0;
    if (state == ST_DBG) begin
      rf_raddr1  = dbg_addr;
      rf_raddr2  = '0;
      rf_waddr   = dbg_addr;
      rf_wdata   = dbg_wdata;
      rf_we      = dbg_we & (dbg_addr != '0);
      core_stall = core_valid;
      dbg_ack    = 1'b1;
    end
  end

  // DBG never lasts more than one cycle.
  a_dbg_single_cycle: assert property (
    @(posedge clk) disable iff (!rst) (state == ST_DBG) |=> (state == ST_CORE)
  );

  // dbg_rvalid is a one-cycle pulse.
  a_rvalid_pulse: assert property (
    @(posedge clk) disable iff (!rst) dbg_rvalid |=> !dbg_rvalid
  );

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Testbench for regfile_port_arbiter. Contains a behavioural register file,
// a debug read-data scoreboard, and one task per scenario.
module tb_regfile_port_arbiter;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic              core_valid, core_we, core_stall;
  logic [ADDR_W-1:0] core_rs, core_rt, core_wa;
  logic [DATA_W-1:0] core_wd;
  logic              dbg_req, dbg_we, dbg_ack, dbg_rvalid;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata, dbg_rdata;
  logic [ADDR_W-1:0] rf_raddr1, rf_raddr2, rf_waddr;
  logic              rf_we;
  logic [DATA_W-1:0] rf_wdata, rf_rdata1;
  logic              arb_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [DATA_W-1:0] exp_q[$];

  regfile_port_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .core_valid(core_valid), .core_rs(core_rs), .core_rt(core_rt),
    .core_we(core_we), .core_wa(core_wa), .core_wd(core_wd), .core_stall(core_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata), .dbg_rvalid(dbg_rvalid),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_we(rf_we),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_rdata1(rf_rdata1),
    .arb_state(arb_state)
  );

  // behavioural register file: combinational read, write on the clock edge
  logic [DATA_W-1:0] tb_rf [32] = '{default: '0};
  assign rf_rdata1 = tb_rf[rf_raddr1];
  always @(posedge clk) if (rf_we === 1'b1) tb_rf[rf_waddr] <= rf_wdata;

  // scoreboard: every dbg_rvalid pulse must match the oldest expected read
  always @(negedge clk) begin
    if (rst === 1'b1 && dbg_rvalid === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL rvalid_unexpected: dbg_rvalid=1 dbg_rdata=%h, no read outstanding", dbg_rdata);
      end else begin
        logic [DATA_W-1:0] e;
        e = exp_q.pop_front();
        if (dbg_rdata !== e) begin
          n_fail++;
          $display("FAIL rdata: got %h expected %h", dbg_rdata, e);
        end
      end
    end
  end

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    core_valid = 1'b0; core_we = 1'b0; core_rs = '0; core_rt = '0;
    core_wa = '0; core_wd = '0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
  endtask

  // Raises a debug request and returns at the falling edge of the ack cycle
  // with the request still held. lat counts the cycles without an ack.
  task automatic dbg_access(input logic we, input logic [ADDR_W-1:0] addr,
                            input logic [DATA_W-1:0] wd, output int lat);
    dbg_req = 1'b1; dbg_we = we; dbg_addr = addr; dbg_wdata = wd;
    lat = 0;
    @(negedge clk);
    while (dbg_ack !== 1'b1 && lat < 40) begin
      lat++;
      @(negedge clk);
    end
    if (dbg_ack !== 1'b1) begin
      n_checks++; n_fail++;
      $display("FAIL dbg_grant_timeout: no dbg_ack within %0d cycles", lat);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    core_rs = 5'd3;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++; if (arb_state !== 1'b0) begin n_fail++; $display("FAIL reset_state: got %b expected 0", arb_state); end
    n_checks++; if (dbg_rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid: got %b expected 0", dbg_rvalid); end
    n_checks++; if (dbg_rdata !== '0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0", dbg_rdata); end
    n_checks++; if (core_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", core_stall); end
    n_checks++; if (dbg_ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b expected 0", dbg_ack); end
    n_checks++; if (rf_raddr1 !== 5'd3) begin n_fail++; $display("FAIL reset_raddr1: got %0d expected 3", rf_raddr1); end
    rst = 1'b1;
    core_rs = '0;
  endtask

  task automatic test_core_write_r0();
    int lat;
    tick();
    core_valid = 1'b1; core_we = 1'b1; core_wa = 5'd5; core_wd = 32'h1234_5678;
    @(negedge clk);
    n_checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'h1234_5678) begin
      n_fail++; $display("FAIL core_write: we=%b wa=%0d wd=%h expected 1/5/12345678", rf_we, rf_waddr, rf_wdata); end
    tick();
    core_wa = 5'd0; core_wd = 32'hFFFF_FFFF;
    @(negedge clk);
    n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL core_write_r0: rf_we got %b expected 0", rf_we); end
    tick();
    idle_inputs();
    dbg_access(1'b1, 5'd0, 32'hFFFF_FFFF, lat);
    n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL dbg_write_r0: rf_we got %b expected 0", rf_we); end
    tick();
    dbg_req = 1'b0;
    @(negedge clk);
    n_checks++; if (tb_rf[0] !== '0) begin n_fail++; $display("FAIL r0_contents: got %h expected 0", tb_rf[0]); end
  endtask

  task automatic test_idle_read();
    int lat;
    tick();
    exp_q.push_back(32'h1234_5678);
    dbg_access(1'b0, 5'd5, '0, lat);
    n_checks++; if (lat != 1) begin n_fail++; $display("FAIL idle_read_latency: got %0d expected 1", lat); end
    n_checks++; if (rf_raddr1 !== 5'd5 || rf_raddr2 !== 5'd0) begin
      n_fail++; $display("FAIL idle_read_addr: raddr1=%0d raddr2=%0d expected 5/0", rf_raddr1, rf_raddr2); end
    n_checks++; if (rf_we !== 1'b0 || core_stall !== 1'b0) begin
      n_fail++; $display("FAIL idle_read_we_stall: we=%b stall=%b expected 0/0", rf_we, core_stall); end
    tick();
    dbg_req = 1'b0;
    @(negedge clk);
    n_checks++; if (dbg_ack !== 1'b0) begin n_fail++; $display("FAIL idle_read_ack_pulse: got %b expected 0", dbg_ack); end
    repeat (2) @(negedge clk);
    n_checks++; if (dbg_rvalid !== 1'b0 || dbg_rdata !== 32'h1234_5678) begin
      n_fail++; $display("FAIL rdata_hold: rvalid=%b rdata=%h expected 0/12345678", dbg_rvalid, dbg_rdata); end
  endtask

  task automatic test_dbg_write();
    int lat;
    tick();
    dbg_access(1'b1, 5'd9, 32'hDEAD_BEEF, lat);
    n_checks++; if (lat != 1) begin n_fail++; $display("FAIL dbg_write_latency: got %0d expected 1", lat); end
    n_checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd9 || rf_wdata !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL dbg_write: we=%b wa=%0d wd=%h expected 1/9/deadbeef", rf_we, rf_waddr, rf_wdata); end
    tick();
    dbg_req = 1'b0;
    @(negedge clk);
    n_checks++; if (dbg_rvalid !== 1'b0 || dbg_rdata !== 32'h1234_5678) begin
      n_fail++; $display("FAIL dbg_write_no_rvalid: rvalid=%b rdata=%h expected 0/12345678", dbg_rvalid, dbg_rdata); end
    tick();
    exp_q.push_back(32'hDEAD_BEEF);
    dbg_access(1'b0, 5'd9, '0, lat);
    tick();
    dbg_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_starvation();
    int lat;
    tick();
    core_valid = 1'b1; core_we = 1'b0; core_rs = 5'd1; core_rt = 5'd2;
    exp_q.push_back(32'hDEAD_BEEF);
    dbg_access(1'b0, 5'd9, '0, lat);
    n_checks++; if (lat != 5) begin n_fail++; $display("FAIL starve_latency: got %0d expected 5", lat); end
    n_checks++; if (core_stall !== 1'b1 || rf_raddr1 !== 5'd9 || rf_raddr2 !== 5'd0) begin
      n_fail++; $display("FAIL starve_grant: stall=%b raddr1=%0d raddr2=%0d expected 1/9/0", core_stall, rf_raddr1, rf_raddr2); end
    tick();
    dbg_req = 1'b0;
    @(negedge clk);
    n_checks++; if (arb_state !== 1'b0 || core_stall !== 1'b0 || rf_raddr1 !== 5'd1 || rf_raddr2 !== 5'd2) begin
      n_fail++; $display("FAIL starve_resume: state=%b stall=%b raddr=%0d/%0d expected 0/0/1/2", arb_state, core_stall, rf_raddr1, rf_raddr2); end
    tick();
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_ack;
    exp_ack = 4'b1010;
    tick();
    exp_q.push_back(32'hDEAD_BEEF);
    exp_q.push_back(32'hDEAD_BEEF);
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd9;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++; if (dbg_ack !== exp_ack[i]) begin
        n_fail++; $display("FAIL back_to_back_ack[%0d]: got %b expected %b", i, dbg_ack, exp_ack[i]); end
    end
    tick();
    dbg_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_priority();
    logic [3:0] exp_ack;
    exp_ack = 4'b1000;
    tick();
    core_valid = 1'b1; core_we = 1'b1; core_wa = 5'd7; core_wd = 32'hA5A5_0001;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd7;
    exp_q.push_back(32'hA5A5_0001);
    @(negedge clk);
    n_checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd7) begin
      n_fail++; $display("FAIL priority_core_write: we=%b wa=%0d expected 1/7", rf_we, rf_waddr); end
    for (int i = 0; i < 4; i++) begin
      if (i == 0) begin
        n_checks++; if (dbg_ack !== exp_ack[i]) begin
          n_fail++; $display("FAIL priority_ack[%0d]: got %b expected %b", i, dbg_ack, exp_ack[i]); end
      end else begin
        tick();
        if (i == 2) begin core_valid = 1'b0; core_we = 1'b0; end
        @(negedge clk);
        n_checks++; if (dbg_ack !== exp_ack[i]) begin
          n_fail++; $display("FAIL priority_ack[%0d]: got %b expected %b", i, dbg_ack, exp_ack[i]); end
      end
    end
    tick();
    dbg_req = 1'b0;
    @(negedge clk);
    n_checks++; if (tb_rf[7] !== 32'hA5A5_0001) begin
      n_fail++; $display("FAIL priority_write_done: r7=%h expected a5a50001", tb_rf[7]); end
  endtask

  task automatic test_reset_mid_dbg();
    int lat;
    tick();
    dbg_access(1'b0, 5'd5, '0, lat);
    core_valid = 1'b1;
    #1;
    n_checks++; if (core_stall !== 1'b1) begin n_fail++; $display("FAIL mid_dbg_stall: got %b expected 1", core_stall); end
    rst = 1'b0;
    #1;
    n_checks++; if (arb_state !== 1'b0 || dbg_ack !== 1'b0) begin
      n_fail++; $display("FAIL mid_dbg_reset_state: state=%b ack=%b expected 0/0", arb_state, dbg_ack); end
    n_checks++; if (dbg_rvalid !== 1'b0 || dbg_rdata !== '0 || core_stall !== 1'b0) begin
      n_fail++; $display("FAIL mid_dbg_reset_outputs: rvalid=%b rdata=%h stall=%b expected 0/0/0", dbg_rvalid, dbg_rdata, core_stall); end
    tick();
    idle_inputs();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (dbg_rvalid !== 1'b0 || dbg_rdata !== '0) begin
      n_fail++; $display("FAIL mid_dbg_dropped: rvalid=%b rdata=%h expected 0/0", dbg_rvalid, dbg_rdata); end
  endtask

  initial begin
    test_reset();
    test_core_write_r0();
    test_idle_read();
    test_dbg_write();
    test_starvation();
    test_back_to_back();
    test_priority();
    test_reset_mid_dbg();
    repeat (3) @(negedge clk);
    n_checks++; if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL reads_outstanding: %0d expected reads never returned", exp_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
